// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit: FSM state encoding,
// the byte-access request latch and the byte-lane helper functions.
package lsu_pkg;

   localparam int WORD_ADDR_W = 8;
   localparam int DATA_W      = 16;
   localparam int BYTE_W      = 8;

   typedef enum logic [1:0] {
      IDLE,
      READ,
      WRITE,
      RESP
   } lsu_state_t;

   // Request fields that only matter for byte accesses.
   typedef struct packed {
      logic              is_byte;
      logic              is_signed;
      logic              lane;
      logic [BYTE_W-1:0] wbyte;
   } lsu_byte_req_t;

   // Little-endian lane select followed by zero- or sign-extension.
   function automatic logic [DATA_W-1:0] extract_byte(
      input logic [DATA_W-1:0] word,
      input logic              lane,
      input logic              sign_ext
   );
      logic [BYTE_W-1:0] sel;
      sel = lane ? word[DATA_W-1:BYTE_W] : word[BYTE_W-1:0];
      return {{(DATA_W-BYTE_W){sign_ext & sel[BYTE_W-1]}}, sel};
   endfunction

   // Replace one lane of the word, keeping the other lane as read.
   function automatic logic [DATA_W-1:0] merge_byte(
      input logic [DATA_W-1:0] word,
      input logic              lane,
      input logic [BYTE_W-1:0] wbyte
   );
      return lane ? {wbyte, word[BYTE_W-1:0]} : {word[DATA_W-1:BYTE_W], wbyte};
   endfunction

endpackage

// File: rtl/load_store_unit_byte_lane.sv
// lsu_byte_lane: combinational byte extract/extend for loads and byte merge
// for read-modify-write stores. Instantiated only when LSU_BYTE_ACCESS_EN is defined.
module lsu_byte_lane
   import lsu_pkg::*;
(
   input  logic [DATA_W-1:0] word,
   input  logic              lane,
   input  logic              sign_ext,
   input  logic [BYTE_W-1:0] wbyte,
   output logic [DATA_W-1:0] load_data,
   output logic [DATA_W-1:0] merged
);

   assign load_data = extract_byte(word, lane, sign_ext);
   assign merged    = merge_byte(word, lane, wbyte);

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: sequences one CPU load/store at a time onto a 256x16 memory.
// Byte loads and read-modify-write byte stores are built only with LSU_BYTE_ACCESS_EN.
module load_store_unit #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic              req_byte,
   input  logic              req_signed,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic [ADDR_W-2:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic              mem_read_en,
   output logic              mem_write_en,
   input  logic [DATA_W-1:0] mem_rdata
);
   import lsu_pkg::*;

   lsu_state_t        state_q, state_d;
   logic              accept;
   logic              byte_req;
   logic              we_q;
   logic [ADDR_W-2:0] mem_addr_q;
   logic [DATA_W-1:0] mem_wdata_q;
   logic [DATA_W-1:0] resp_rdata_q;
   logic [DATA_W-1:0] load_result;
   logic [DATA_W-1:0] store_word;

`ifdef LSU_BYTE_ACCESS_EN
   lsu_byte_req_t     byte_q;
   logic [DATA_W-1:0] lane_load;
   logic [DATA_W-1:0] lane_merged;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         byte_q <= '0;
      end else if (accept) begin
         byte_q <= '{is_byte:   req_byte,
                     is_signed: req_signed,
                     lane:      req_addr[0],
                     wbyte:     req_wdata[BYTE_W-1:0]};
      end
   end

   lsu_byte_lane u_byte_lane (
      .word      (mem_rdata),
      .lane      (byte_q.lane),
      .sign_ext  (byte_q.is_signed),
      .wbyte     (byte_q.wbyte),
      .load_data (lane_load),
      .merged    (lane_merged)
   );

   assign byte_req    = req_byte;
   assign load_result = byte_q.is_byte ? lane_load : mem_rdata;
   assign store_word  = lane_merged;
`else
   // Byte controls and the lane bit have no function in a word-only build.
   logic unused_ok;
   assign unused_ok = &{1'b0, req_byte, req_signed, req_addr[0]};

   assign byte_req    = 1'b0;
   assign load_result = mem_rdata;
   // Stores never pass through READ here, so this path is never selected.
   assign store_word  = mem_rdata;
`endif

   assign accept = req_ready & req_valid;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: every output gets a default before the case, so no latches are inferred.
   always_comb begin
      state_d      = state_q;
      req_ready    = 1'b0;
      resp_valid   = 1'b0;
      mem_read_en  = 1'b0;
      mem_write_en = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_d = (req_we && !byte_req) ? WRITE : READ;
            end
         end
         READ: begin
            mem_read_en = 1'b1;
            state_d     = we_q ? WRITE : RESP;
         end
         WRITE: begin
            mem_write_en = 1'b1;
            state_d      = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Address and write data are registered at accept so they are stable for the
   // whole access and simply hold afterwards.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         we_q         <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         resp_rdata_q <= '0;
      end else begin
         if (accept) begin
            we_q       <= req_we;
            mem_addr_q <= req_addr[ADDR_W-1:1];
            if (req_we && !byte_req) begin
               mem_wdata_q <= req_wdata;
            end
         end
         if (state_q == READ) begin
            if (we_q) begin
               mem_wdata_q <= store_word;
            end else begin
               resp_rdata_q <= load_result;
            end
         end
         if (state_q == WRITE) begin
            resp_rdata_q <= '0;
         end
      end
   end

   assign mem_addr   = mem_addr_q;
   assign mem_wdata  = mem_wdata_q;
   assign resp_rdata = resp_rdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: behavioural 256x16 memory, reference
// model with a scoreboard queue, latency/handshake/backpressure/reset checks.
module tb_load_store_unit;

`ifdef LSU_BYTE_ACCESS_EN
   localparam bit BYTE_EN = 1'b1;
`else
   localparam bit BYTE_EN = 1'b0;
`endif

   logic        clk;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic        req_we;
   logic        req_byte;
   logic        req_signed;
   logic [8:0]  req_addr;
   logic [15:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [15:0] resp_rdata;
   logic [7:0]  mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_read_en;
   logic        mem_write_en;
   logic [15:0] mem_rdata;

   typedef struct {
      logic [15:0] rdata;
      int          lat;
      logic        rd;
      logic        wr;
      logic [7:0]  waddr;
      logic [15:0] wword;
   } exp_t;

   exp_t        sb_q[$];
   logic [15:0] mem     [256];
   logic [15:0] ref_mem [256];
   int          errors = 0;
   int          checks = 0;

   load_store_unit #(.ADDR_W(9), .DATA_W(16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_ready    (req_ready),
      .req_we       (req_we),
      .req_byte     (req_byte),
      .req_signed   (req_signed),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .resp_valid   (resp_valid),
      .resp_ready   (resp_ready),
      .resp_rdata   (resp_rdata),
      .mem_addr     (mem_addr),
      .mem_wdata    (mem_wdata),
      .mem_read_en  (mem_read_en),
      .mem_write_en (mem_write_en),
      .mem_rdata    (mem_rdata)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   assign mem_rdata = mem[mem_addr];
   always @(posedge clk) begin
      if (mem_write_en) mem[mem_addr] <= mem_wdata;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_req_ready"},  req_ready,    1);
      check({tag, "_resp_valid"}, resp_valid,   0);
      check({tag, "_resp_rdata"}, resp_rdata,   0);
      check({tag, "_mem_addr"},   mem_addr,     0);
      check({tag, "_mem_wdata"},  mem_wdata,    0);
      check({tag, "_mem_rd"},     mem_read_en,  0);
      check({tag, "_mem_wr"},     mem_write_en, 0);
   endtask

   task automatic drive_junk();
      req_valid  = 1'b1;
      req_we     = 1'($urandom_range(0, 1));
      req_byte   = 1'($urandom_range(0, 1));
      req_signed = 1'($urandom_range(0, 1));
      req_addr   = 9'($urandom);
      req_wdata  = 16'($urandom);
   endtask

   // Issue one request, predict its outcome, then follow it through to the response.
   task automatic do_req(input logic we, input logic is_byte, input logic sgn,
                         input logic [8:0] addr, input logic [15:0] wdata, input int hold);
      exp_t        e, got_e;
      logic        byte_mode;
      logic [15:0] w;
      logic [7:0]  b;
      int          n, lat;
      logic        saw_rd, saw_wr;
      logic [7:0]  rd_addr, wr_addr;
      logic [15:0] wr_word;

      byte_mode = BYTE_EN && is_byte;
      w = ref_mem[addr[8:1]];
      b = addr[0] ? w[15:8] : w[7:0];
      e.waddr = addr[8:1];
      if (we) begin
         e.wword = byte_mode ? (addr[0] ? {wdata[7:0], w[7:0]} : {w[15:8], wdata[7:0]}) : wdata;
         ref_mem[addr[8:1]] = e.wword;
         e.rdata = 16'h0000;
         e.lat   = byte_mode ? 3 : 2;
         e.rd    = byte_mode;
         e.wr    = 1'b1;
      end else begin
         e.wword = 16'h0000;
         e.rdata = byte_mode ? {{8{sgn & b[7]}}, b} : w;
         e.lat   = 2;
         e.rd    = 1'b1;
         e.wr    = 1'b0;
      end
      sb_q.push_back(e);

      n = 0;
      while (!req_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check("accept_wait", n, 0);

      resp_ready = (hold == 0);
      req_valid  = 1'b1;
      req_we     = we;
      req_byte   = is_byte;
      req_signed = sgn;
      req_addr   = addr;
      req_wdata  = wdata;
      @(negedge clk);
      drive_junk();

      lat = 1; saw_rd = 0; saw_wr = 0; rd_addr = 0; wr_addr = 0; wr_word = 0;
      while (!resp_valid && lat < 10) begin
         check("busy_req_ready", req_ready, 0);
         if (mem_read_en)  begin saw_rd = 1; rd_addr = mem_addr; end
         if (mem_write_en) begin saw_wr = 1; wr_addr = mem_addr; wr_word = mem_wdata; end
         @(negedge clk);
         lat++;
      end
      req_valid = 1'b0;

      got_e = sb_q.pop_front();
      check("latency",    lat,        got_e.lat);
      check("resp_rdata", resp_rdata, got_e.rdata);
      check("read_seen",  saw_rd,     got_e.rd);
      check("write_seen", saw_wr,     got_e.wr);
      if (got_e.rd) check("read_addr", rd_addr, got_e.waddr);
      if (got_e.wr) begin
         check("write_addr", wr_addr, got_e.waddr);
         check("write_data", wr_word, got_e.wword);
      end

      if (hold > 0) begin
         req_valid  = 1'b1;
         req_we     = 1'b1;
         req_byte   = 1'b0;
         req_addr   = 9'h020;
         req_wdata  = 16'hDEAD;
         for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("bp_resp_valid", resp_valid,   1);
            check("bp_resp_rdata", resp_rdata,   got_e.rdata);
            check("bp_req_ready",  req_ready,    0);
            check("bp_mem_rd",     mem_read_en,  0);
            check("bp_mem_wr",     mem_write_en, 0);
         end
         req_valid  = 1'b0;
         resp_ready = 1'b1;
      end
      @(negedge clk);
   endtask

   // Reset pulse right after accepting a byte store to word 0x10.
   task automatic reset_mid_byte_store();
      logic [15:0] old;
      old = ref_mem[8'h10];
      check("rst_idle", req_ready, 1);
      resp_ready = 1'b1;
      req_valid  = 1'b1;
      req_we     = 1'b1;
      req_byte   = 1'b1;
      req_signed = 1'b0;
      req_addr   = 9'h021;
      req_wdata  = 16'h00EE;
      @(negedge clk);
      req_valid = 1'b0;
      check("rst_pre_rd", mem_read_en,  BYTE_EN);
      check("rst_pre_wr", mem_write_en, !BYTE_EN);
      rst_n = 1'b0;
      #1;
      check_reset_outputs("rst_mid");
      @(negedge clk);
      check_reset_outputs("rst_hold");
      check("rst_word_kept", mem[8'h10], old);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_word_after", mem[8'h10], old);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      for (int i = 0; i < 256; i++) begin
         mem[i]     = 16'h0000;
         ref_mem[i] = 16'h0000;
      end
      rst_n      = 1'b0;
      req_valid  = 1'b0;
      req_we     = 1'b0;
      req_byte   = 1'b0;
      req_signed = 1'b0;
      req_addr   = '0;
      req_wdata  = '0;
      resp_ready = 1'b1;
      repeat (2) @(negedge clk);
      check_reset_outputs("reset");
      rst_n = 1'b1;
      @(negedge clk);

      do_req(1'b1, 1'b0, 1'b0, 9'h020, 16'h1234, 0);
      do_req(1'b0, 1'b0, 1'b0, 9'h020, 16'h0000, 0);
      do_req(1'b1, 1'b1, 1'b0, 9'h021, 16'h00AB, 0);
      do_req(1'b0, 1'b0, 1'b0, 9'h020, 16'h0000, 0);
      do_req(1'b1, 1'b0, 1'b0, 9'h020, 16'h1234, 0);
      do_req(1'b1, 1'b1, 1'b0, 9'h021, 16'h00CD, 0);
      do_req(1'b0, 1'b0, 1'b0, 9'h020, 16'h0000, 0);

      do_req(1'b1, 1'b0, 1'b0, 9'h040, 16'h0080, 0);
      do_req(1'b0, 1'b1, 1'b1, 9'h040, 16'h0000, 0);
      do_req(1'b0, 1'b1, 1'b0, 9'h040, 16'h0000, 0);
      do_req(1'b0, 1'b1, 1'b1, 9'h041, 16'h0000, 0);

      do_req(1'b0, 1'b0, 1'b0, 9'h040, 16'h0000, 3);
      do_req(1'b1, 1'b1, 1'b1, 9'h040, 16'h5A7F, 3);
      do_req(1'b0, 1'b0, 1'b0, 9'h040, 16'h0000, 0);

      for (int i = 0; i < 24; i++) begin
         do_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                {6'b000100, 3'($urandom_range(0, 7))}, 16'($urandom), 0);
      end

      do_req(1'b1, 1'b0, 1'b0, 9'h020, 16'h1234, 0);
      reset_mid_byte_store();
      do_req(1'b0, 1'b0, 1'b0, 9'h020, 16'h0000, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sequencer between the multi-cycle CPU control FSM and the 256×16 data memory. Accepts one load or store request at a time over a valid/ready handshake and drives the memory's address, write-data and read/write enables. Supports word and byte accesses: byte stores are done as read-modify-write, and byte loads are zero- or sign-extended. Returns a registered response that is held until the CPU accepts it.

## Interface
Parameters:
- ADDR_W, 9: CPU byte-address width. Word address is addr[8:1]; addr[0] is the byte lane.
- DATA_W, 16: memory word width. Fixed at 16; other values are unsupported.

Ports:
- clk  in  1  single clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  CPU request present.
- req_ready  out  1  unit can accept a request; high only in IDLE.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = word access.
- req_signed  in  1  byte load only: 1 = sign-extend, 0 = zero-extend.
- req_addr  in  9  byte address.
- req_wdata  in  16  store data; byte stores use bits [7:0].
- resp_valid  out  1  response available.
- resp_ready  in  1  CPU takes the response.
- resp_rdata  out  16  load result; 0 for stores.
- mem_addr  out  8  word address to memory.
- mem_wdata  out  16  word written to memory.
- mem_read_en  out  1  memory read enable. Memory read data is combinational.
- mem_write_en  out  1  memory write enable; the write commits on the next clk edge.
- mem_rdata  in  16  memory read data.

## Operation
- States: IDLE, READ, WRITE, RESP.
- IDLE: req_ready=1. On req_valid & req_ready, latch we, byte, signed, addr and wdata. Next state:
  - word load, byte load, byte store: READ
  - word store: WRITE
- READ: mem_read_en=1 and mem_addr=addr[8:1]. Capture mem_rdata into the data register.
  - Load: form the result, then go to RESP.
  - Byte store: merge the byte into the captured word, then go to WRITE.
- Byte lanes are little-endian: addr[0]=0 selects bits [7:0]; addr[0]=1 selects bits [15:8].
- Byte load result: {8{signed & byte[7]}, byte}.
- Byte store merge: replace only the selected lane with wdata[7:0]; the other lane keeps the value read.
- WRITE: mem_write_en=1, mem_wdata = merged word (byte store) or latched wdata (word store). Next state RESP with resp_rdata=0.
- RESP: resp_valid=1 and resp_rdata is held stable. When resp_ready=1, go to IDLE. Both memory enables are 0 in RESP.
- req_ready is 0 in every state except IDLE. Requests are not queued.
- Enables are decoded from the registered state, so they are glitch-free.
- mem_addr and mem_wdata hold their last values in IDLE and RESP.

## Timing
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, mem_addr=0, mem_wdata=0, mem_read_en=0, mem_write_en=0.
- Cycles from the accept edge to resp_valid=1:
  - word load: 2
  - word store: 2
  - byte load: 2
  - byte store: 3
- Back-to-back: with resp_ready held at 1, the next request is accepted on the cycle after RESP.
  - Throughput: one word access per 3 cycles; one byte store per 4 cycles.
- A load issued right after a store to the same word returns the new data, because the store commits on the WRITE→RESP edge.
- Reset mid-operation (any state): immediately return to IDLE with all outputs at reset values.
  - A byte store interrupted in READ writes nothing.
  - A store interrupted in WRITE writes nothing if rst_n falls before the clk edge.
- req_valid, req_addr and the other request fields are ignored outside IDLE.

## Configuration
- LSU_BYTE_ACCESS_EN defined: byte loads, byte stores and sign-extension work as described above.
- LSU_BYTE_ACCESS_EN undefined: req_byte and req_signed are ignored.
  - Every access is a word access at addr[8:1]; addr[0] is ignored.
  - No read-modify-write path exists, so byte stores overwrite the full word with req_wdata.
  - The merge/extract logic is not built.

## Structure
- Package lsu_pkg holds:
  - lsu_state_t enum (IDLE, READ, WRITE, RESP)
  - localparams WORD_ADDR_W=8 and DATA_W=16
- Sub-module lsu_byte_lane: purely combinational byte extract/extend and byte merge. It is instantiated only under LSU_BYTE_ACCESS_EN.
- The top level contains the FSM, request latch, data register and handshake logic.

## Test plan
- Word store 0x1234 at addr 0x020, then word load at 0x020: resp_rdata=0x1234; resp_valid is high 2 cycles after each accept.
- Byte store 0xAB at addr 0x021 over the stored 0x1234, then word load at 0x020: 0xAB34; the byte store responds 3 cycles after accept.
- Word 0x0080 at addr 0x040, byte load at 0x040:
  - signed: 0xFF80
  - unsigned: 0x0080
  - byte load at 0x041: 0x0000
- Backpressure: resp_ready low for 3 cycles while req_valid is high:
  - resp_valid and resp_rdata stay stable
  - req_ready stays 0
  - memory enables stay 0
  - the next request is accepted the cycle after resp_ready goes high
- rst_n pulsed low while in READ of a byte store to 0x021: all outputs return to reset values, mem_write_en is never asserted, and the word at 0x020 is unchanged.
- LSU_BYTE_ACCESS_EN undefined, byte store of 0x00CD at 0x021 over 0x1234: word load at 0x020 returns 0x00CD.
